// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a simple command/response port.
// A per-transaction watchdog turns a stuck slave into an error response (RESP=2'b10).
module axi_lite_cmd_master #(
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int C_M00_AXI_ADDR_WIDTH = 14,
  parameter int C_TIMEOUT            = 1024
) (
  input  logic                                m00_axi_aclk,
  input  logic                                m00_axi_aresetn,

  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_write,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                          rsp_resp,
  output logic                                rsp_timeout,

  output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
  output logic [2:0]                          m00_axi_awprot,
  output logic                                m00_axi_awvalid,
  input  logic                                m00_axi_awready,

  output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
  output logic                                m00_axi_wvalid,
  input  logic                                m00_axi_wready,

  input  logic [1:0]                          m00_axi_bresp,
  input  logic                                m00_axi_bvalid,
  output logic                                m00_axi_bready,

  output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
  output logic [2:0]                          m00_axi_arprot,
  output logic                                m00_axi_arvalid,
  input  logic                                m00_axi_arready,

  input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
  input  logic [1:0]                          m00_axi_rresp,
  input  logic                                m00_axi_rvalid,
  output logic                                m00_axi_rready
);

  localparam int DW = C_M00_AXI_DATA_WIDTH;
  localparam int AW = C_M00_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam int CW = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT + 1) : 1;
  localparam bit TO_EN = (C_TIMEOUT > 0);
  localparam logic [CW-1:0] TO_LAST = (C_TIMEOUT > 0) ? CW'(C_TIMEOUT - 1) : '0;

  // state          | meaning
  // S_IDLE         | waiting for a command, cmd_ready high
  // S_WR_ADDR_DATA | AW and W offered independently until both handshake
  // S_WR_RESP      | waiting for B
  // S_RD_ADDR      | AR offered
  // S_RD_DATA      | waiting for R
  // S_RSP          | response held until rsp_ready
  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            write_q, write_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            arvalid_q, arvalid_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      resp_q, resp_d;
  logic            timeout_q, timeout_d;
  logic            busy;
  logic            aw_done, w_done;

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
    end
  end

  // A channel counts as done once its valid has already dropped or handshakes now.
  assign aw_done = !awvalid_q || m00_axi_awready;
  assign w_done  = !wvalid_q  || m00_axi_wready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    busy      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          cnt_d     = '0;
          timeout_d = 1'b0;
          if (cmd_write) begin
            state_d   = S_WR_ADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR_ADDR_DATA: begin
        busy = 1'b1;
        if (awvalid_q && m00_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m00_axi_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        busy = 1'b1;
        if (m00_axi_bvalid) begin
          resp_d  = m00_axi_bresp;
          rdata_d = '0;
          state_d = S_RSP;
        end
      end
      S_RD_ADDR: begin
        busy = 1'b1;
        if (m00_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        busy = 1'b1;
        if (m00_axi_rvalid) begin
          resp_d  = m00_axi_rresp;
          rdata_d = m00_axi_rdata;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (busy) cnt_d = cnt_q + 1'b1;

    // Watchdog abort wins over any handshake in the same cycle.
    if (busy && TO_EN && (cnt_q == TO_LAST)) begin
      state_d   = S_RSP;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      rdata_d   = '0;
      resp_d    = 2'b10;
      timeout_d = 1'b1;
    end
  end

  assign cmd_ready       = (state_q == S_IDLE) && m00_axi_aresetn;
  assign rsp_valid       = (state_q == S_RSP);
  assign rsp_rdata       = rdata_q;
  assign rsp_resp        = resp_q;
  assign rsp_timeout     = timeout_q;

  assign m00_axi_awaddr  = addr_q;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awvalid = awvalid_q;
  assign m00_axi_wdata   = wdata_q;
  assign m00_axi_wstrb   = wstrb_q;
  assign m00_axi_wvalid  = wvalid_q;
  assign m00_axi_bready  = (state_q == S_WR_RESP) && write_q;
  assign m00_axi_araddr  = addr_q;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_arvalid = arvalid_q;
  assign m00_axi_rready  = (state_q == S_RD_DATA) && !write_q;

endmodule

// File: doc/axi_lite_cmd_master.md
AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
- REQ-001 SHALL have parameter C_M00_AXI_DATA_WIDTH, default 32; AXI data width.
- REQ-002 SHALL have parameter C_M00_AXI_ADDR_WIDTH, default 14; AXI address width.
- REQ-003 SHALL have parameter C_TIMEOUT, default 1024; max cycles per transaction; 0 disables the timeout.
- REQ-004 m00_axi_aclk  in  1  single clock; all logic on rising edge.
- REQ-005 m00_axi_aresetn  in  1  asynchronous, active-low reset.
- REQ-006 cmd_valid  in  1  command request.
- REQ-007 cmd_ready  out  1  high only in IDLE.
- REQ-008 cmd_write  in  1  1 = write, 0 = read.
- REQ-009 cmd_addr  in  ADDR_WIDTH  target byte address.
- REQ-010 cmd_wdata  in  DATA_WIDTH  write data.
- REQ-011 cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
- REQ-012 rsp_valid  out  1  response available; held until rsp_ready.
- REQ-013 rsp_ready  in  1  response consumed.
- REQ-014 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- REQ-015 rsp_resp  out  2  captured BRESP/RRESP, or 2'b10 on timeout.
- REQ-016 rsp_timeout  out  1  transaction aborted by timeout.
- REQ-017 AW channel: m00_axi_awaddr/awprot/awvalid out, m00_axi_awready in; awprot = 3'b000.
- REQ-018 W channel: m00_axi_wdata/wstrb/wvalid out, m00_axi_wready in.
- REQ-019 B channel: m00_axi_bresp/bvalid in, m00_axi_bready out.
- REQ-020 AR channel: m00_axi_araddr/arprot/arvalid out, m00_axi_arready in; arprot = 3'b000.
- REQ-021 R channel: m00_axi_rdata/rresp/rvalid in, m00_axi_rready out.

Function
- REQ-022 FSM states SHALL be IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- REQ-023 Command accepted on an edge with cmd_valid & cmd_ready; addr/wdata/wstrb/write SHALL be registered at that edge.
- REQ-024 Write accept SHALL go IDLE->WR_ADDR_DATA, with awvalid and wvalid both high from the next cycle.
- REQ-025 awvalid SHALL drop the cycle after its own awready handshake; wvalid likewise on wready, independently, in either order or simultaneously.
- REQ-026 Once both AW and W have handshaked: ->WR_RESP; bready=1 only in WR_RESP; B handshake ->RSP capturing bresp.
- REQ-027 Read accept SHALL go IDLE->RD_ADDR with arvalid high; AR handshake ->RD_DATA.
- REQ-028 In RD_DATA, rready=1; R handshake ->RSP capturing rdata and rresp.
- REQ-029 In RSP, rsp_valid=1; rsp_ready ->IDLE, with rsp_valid low the next cycle.
- REQ-030 Once asserted, valid signals SHALL NOT drop and address/data SHALL NOT change before their handshake.
- REQ-031 Minimum latency with zero-wait slave and rsp_ready tied high: write accept to rsp_valid = 3 cycles; read = 3 cycles.
- REQ-032 Timeout counter SHALL clear on command accept and count every cycle outside IDLE/RSP; at C_TIMEOUT it SHALL drop all AXI valids/readies, enter RSP, set rsp_timeout=1 and rsp_resp=2'b10.
- REQ-033 cmd_valid while busy SHALL be ignored; there is no queueing.
- REQ-034 A late bvalid/rvalid after a timeout SHALL be ignored; it is a debug-only abort.

Reset
- REQ-035 Asserted reset SHALL immediately force IDLE, all AXI valid/ready outputs 0, rsp_valid 0, rsp_timeout 0, rsp_rdata 0, rsp_resp 0, addresses/data 0, and counter 0.
- REQ-036 Reset mid-transaction SHALL abandon it with no response; first command after deassertion SHALL behave normally.

Verification
- REQ-037 Write 0x12345678 to 0x0 on a zero-wait 4-register slave model -> one AW and one W handshake, wstrb=4'hF, rsp_valid 3 cycles after accept, rsp_resp=00.
- REQ-038 Write 0x55AA55AA to 0x4, then read 0x4 -> rsp_rdata=0x55AA55AA; repeat for 0x8=0xAA66AA66 and 0xC=0x54213698.
- REQ-039 Slave awready 3 cycles late, wready immediate -> wvalid drops first, awvalid holds stable until handshake, single response.
- REQ-040 rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable; cmd_ready stays 0 until release.
- REQ-041 C_TIMEOUT=16 with slave never asserting arready -> rsp_valid at cycle 16, rsp_timeout=1, rsp_resp=10, arvalid=0.
- REQ-042 Reset asserted during WR_RESP -> all outputs 0 asynchronously; subsequent read to 0x0 completes normally.
